// File: rtl/obi_pkg.sv
// Shared OBI types and master-ID constants used by the arbiter, the address
// demux and the memory-side adapters.
package obi_pkg;

    localparam logic M0_ID = 1'b0;
    localparam logic M1_ID = 1'b1;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_rsp_t;

endpackage

// File: rtl/obi_arbiter_2_to_1_if.sv
// One OBI link: the address phase flows master -> slave, the grant and the
// response flow back.
interface obi_arbiter_2_to_1_if;

    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/obi_id_fifo.sv
// In-order FIFO of 1-bit master IDs, one entry per outstanding transaction.
// Pushes are ignored when full and pops when empty.
module obi_id_fifo #(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          id_i,
    input  logic          pop_i,
    output logic          id_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign id_o    = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= id_i;
        end
    end

endmodule

// File: rtl/obi_arbiter_2_to_1.sv
// Round-robin 2-to-1 OBI arbiter: combinational address path with a grant lock,
// and in-order response routing through an ID FIFO.
module obi_arbiter_2_to_1
    import obi_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    obi_arbiter_2_to_1_if.slave    m0_bus,
    obi_arbiter_2_to_1_if.slave    m1_bus,
    obi_arbiter_2_to_1_if.master   dn_bus,
    output logic                   err_o
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    obi_req_t      m0_req, m1_req, sel_req;
    logic          sel;
    logic          locked_q, locked_d;
    logic          lock_q, lock_d;
    logic          last_q, last_d;
    logic          req_fwd, handshake, rsp_ok;
    logic          fifo_full, fifo_empty, head_id;
    logic [CW-1:0] id_count;

    // A pending (locked) selection overrides round-robin until it is granted.
    always_comb begin
        m0_req = '{req: m0_bus.req, addr: m0_bus.addr, we: m0_bus.we,
                   be: m0_bus.be, wdata: m0_bus.wdata};
        m1_req = '{req: m1_bus.req, addr: m1_bus.addr, we: m1_bus.we,
                   be: m1_bus.be, wdata: m1_bus.wdata};
        if (locked_q) begin
            sel = lock_q;
        end else if (m0_req.req && m1_req.req) begin
            sel = ~last_q;
        end else if (m1_req.req) begin
            sel = M1_ID;
        end else begin
            sel = M0_ID;
        end
        sel_req = (sel == M1_ID) ? m1_req : m0_req;
    end

    assign req_fwd   = sel_req.req & ~fifo_full & ~rst_i;
    assign handshake = req_fwd & dn_bus.gnt;

    assign dn_bus.req   = req_fwd;
    assign dn_bus.addr  = sel_req.addr;
    assign dn_bus.we    = sel_req.we;
    assign dn_bus.be    = sel_req.be;
    assign dn_bus.wdata = sel_req.wdata;

    assign m0_bus.gnt = handshake & (sel == M0_ID);
    assign m1_bus.gnt = handshake & (sel == M1_ID);

    // Responses with nothing outstanding are dropped and flagged.
    assign rsp_ok        = dn_bus.rvalid & ~fifo_empty & ~rst_i;
    assign m0_bus.rvalid = rsp_ok & (head_id == M0_ID);
    assign m1_bus.rvalid = rsp_ok & (head_id == M1_ID);
    assign m0_bus.rdata  = dn_bus.rdata;
    assign m1_bus.rdata  = dn_bus.rdata;
    assign err_o         = dn_bus.rvalid & fifo_empty & ~rst_i;

    always_comb begin
        locked_d = locked_q;
        lock_d   = lock_q;
        last_d   = last_q;
        if (handshake) begin
            locked_d = 1'b0;
            last_d   = sel;
        end else if (req_fwd) begin
            locked_d = 1'b1;
            lock_d   = sel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            locked_q <= 1'b0;
            lock_q   <= M0_ID;
            last_q   <= M1_ID;
        end else begin
            locked_q <= locked_d;
            lock_q   <= lock_d;
            last_q   <= last_d;
        end
    end

    obi_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (handshake),
        .id_i    (sel),
        .pop_i   (rsp_ok),
        .id_o    (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (id_count)
    );

endmodule

// File: tb/tb_obi_arbiter_2_to_1.sv
// Scenario bench for the 2-to-1 OBI arbiter; expected response owners are
// queued at grant time and checked when the response is driven.
module tb_obi_arbiter_2_to_1;

    logic clk = 1'b0;
    logic rst;
    logic err;

    always #5 clk = ~clk;

    obi_arbiter_2_to_1_if m0_bus ();
    obi_arbiter_2_to_1_if m1_bus ();
    obi_arbiter_2_to_1_if dn_bus ();

    obi_arbiter_2_to_1 #(.MAX_OUTSTANDING(2)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .m0_bus (m0_bus),
        .m1_bus (m1_bus),
        .dn_bus (dn_bus),
        .err_o  (err)
    );

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    logic last_model;

    task automatic idle();
        m0_bus.req = 1'b0; m0_bus.addr = '0; m0_bus.we = 1'b0; m0_bus.be = '0; m0_bus.wdata = '0;
        m1_bus.req = 1'b0; m1_bus.addr = '0; m1_bus.we = 1'b0; m1_bus.be = '0; m1_bus.wdata = '0;
        dn_bus.gnt = 1'b0; dn_bus.rvalid = 1'b0; dn_bus.rdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        m0_bus.req = 1'b1; m1_bus.req = 1'b1;
        dn_bus.gnt = 1'b1; dn_bus.rvalid = 1'b1; dn_bus.rdata = 32'hA5A5_5A5A;
        #1;
        tests++; if (dn_bus.req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", dn_bus.req); end
        tests++; if ({m1_bus.gnt, m0_bus.gnt} !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b want 00", {m1_bus.gnt, m0_bus.gnt}); end
        tests++; if ({m1_bus.rvalid, m0_bus.rvalid} !== 2'b00) begin fails++; $display("FAIL reset_rvalid: got %b want 00", {m1_bus.rvalid, m0_bus.rvalid}); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
        tests++; if (m0_bus.rdata !== 32'hA5A5_5A5A || m1_bus.rdata !== 32'hA5A5_5A5A) begin
            fails++; $display("FAIL reset_rdata: got %h/%h want a5a55a5a", m0_bus.rdata, m1_bus.rdata);
        end
        tests++; if (dut.id_count !== 0) begin fails++; $display("FAIL reset_count: got %0d want 0", dut.id_count); end
        step();
        idle();
        step();
        rst = 1'b0;
        last_model = 1'b1;
        sb.delete();
    endtask

    task automatic test_tie();
        logic g;
        for (int k = 0; k < 4; k++) begin
            m0_bus.req = 1'b1; m0_bus.addr = 32'h0000_2000 + k;
            m1_bus.req = 1'b1; m1_bus.addr = 32'h0000_3000 + k;
            dn_bus.gnt = 1'b1;
            dn_bus.rvalid = 1'b0;
            if (k > 0) begin
                e = sb.pop_front();
                dn_bus.rvalid = 1'b1; dn_bus.rdata = e.data;
            end
            #1;
            g = ~last_model;
            tests++; if ({m1_bus.gnt, m0_bus.gnt} !== (g ? 2'b10 : 2'b01)) begin
                fails++; $display("FAIL tie_gnt[%0d]: got %b want %b", k, {m1_bus.gnt, m0_bus.gnt}, (g ? 2'b10 : 2'b01));
            end
            tests++; if (dn_bus.addr !== (g ? 32'h0000_3000 + k : 32'h0000_2000 + k)) begin
                fails++; $display("FAIL tie_addr[%0d]: got %h", k, dn_bus.addr);
            end
            if (k > 0) begin
                tests++; if ({m1_bus.rvalid, m0_bus.rvalid} !== (e.id ? 2'b10 : 2'b01)) begin
                    fails++; $display("FAIL tie_route[%0d]: got %b want %b", k, {m1_bus.rvalid, m0_bus.rvalid}, (e.id ? 2'b10 : 2'b01));
                end
            end
            sb.push_back('{id: g, data: 32'hC000_0000 + k});
            last_model = g;
            step();
        end
        idle();
        e = sb.pop_front();
        dn_bus.rvalid = 1'b1; dn_bus.rdata = e.data;
        #1;
        tests++; if ({m1_bus.rvalid, m0_bus.rvalid} !== (e.id ? 2'b10 : 2'b01)) begin
            fails++; $display("FAIL tie_route_last: got %b want %b", {m1_bus.rvalid, m0_bus.rvalid}, (e.id ? 2'b10 : 2'b01));
        end
        tests++; if ((e.id ? m1_bus.rdata : m0_bus.rdata) !== e.data) begin
            fails++; $display("FAIL tie_rdata: got %h want %h", (e.id ? m1_bus.rdata : m0_bus.rdata), e.data);
        end
        step();
        idle();
    endtask

    task automatic test_single();
        idle();
        m0_bus.req = 1'b1; m0_bus.addr = 32'h0000_1000; dn_bus.gnt = 1'b1;
        #1;
        tests++; if ({m1_bus.gnt, m0_bus.gnt} !== 2'b01) begin fails++; $display("FAIL single_gnt: got %b want 01", {m1_bus.gnt, m0_bus.gnt}); end
        tests++; if (dn_bus.addr !== 32'h0000_1000 || dn_bus.we !== 1'b0) begin
            fails++; $display("FAIL single_addr: got %h/%b want 00001000/0", dn_bus.addr, dn_bus.we);
        end
        sb.push_back('{id: 1'b0, data: 32'h1234_5678});
        last_model = 1'b0;
        step();
        idle();
        e = sb.pop_front();
        dn_bus.rvalid = 1'b1; dn_bus.rdata = e.data;
        #1;
        tests++; if ({m1_bus.rvalid, m0_bus.rvalid} !== 2'b01) begin fails++; $display("FAIL single_route: got %b want 01", {m1_bus.rvalid, m0_bus.rvalid}); end
        tests++; if (m0_bus.rdata !== 32'h1234_5678) begin fails++; $display("FAIL single_rdata: got %h want 12345678", m0_bus.rdata); end
        step();
        idle();
    endtask

    task automatic test_push_pop();
        idle();
        for (int k = 0; k < 4; k++) begin
            m1_bus.req = 1'b1; m1_bus.addr = 32'h0000_7000 + k; dn_bus.gnt = 1'b1;
            dn_bus.rvalid = 1'b0;
            if (k > 0) begin
                e = sb.pop_front();
                dn_bus.rvalid = 1'b1; dn_bus.rdata = e.data;
            end
            #1;
            tests++; if ({m1_bus.gnt, m0_bus.gnt} !== 2'b10) begin fails++; $display("FAIL pp_gnt[%0d]: got %b want 10", k, {m1_bus.gnt, m0_bus.gnt}); end
            if (k > 0) begin
                tests++; if (dut.id_count !== 1) begin fails++; $display("FAIL pp_count[%0d]: got %0d want 1", k, dut.id_count); end
                tests++; if ({m1_bus.rvalid, m0_bus.rvalid} !== 2'b10 || m1_bus.rdata !== e.data) begin
                    fails++; $display("FAIL pp_route[%0d]: got %b/%h want 10/%h", k, {m1_bus.rvalid, m0_bus.rvalid}, m1_bus.rdata, e.data);
                end
            end
            sb.push_back('{id: 1'b1, data: 32'hD000_0000 + k});
            last_model = 1'b1;
            step();
        end
        idle();
        e = sb.pop_front();
        dn_bus.rvalid = 1'b1; dn_bus.rdata = e.data;
        #1;
        tests++; if ({m1_bus.rvalid, m0_bus.rvalid} !== 2'b10) begin fails++; $display("FAIL pp_route_last: got %b want 10", {m1_bus.rvalid, m0_bus.rvalid}); end
        step();
        idle();
        #1;
        tests++; if (dut.id_count !== 0) begin fails++; $display("FAIL pp_drain: got %0d want 0", dut.id_count); end
    endtask

    task automatic test_lock();
        idle();
        m1_bus.req = 1'b1; m1_bus.addr = 32'h0000_4444; m1_bus.we = 1'b1; m1_bus.be = 4'hF; m1_bus.wdata = 32'hCAFE_0001;
        for (int c = 0; c < 3; c++) begin
            if (c >= 1) begin
                m0_bus.req = 1'b1; m0_bus.addr = 32'h0000_5555;
            end
            #1;
            tests++; if (dn_bus.addr !== 32'h0000_4444 || dn_bus.we !== 1'b1 || dn_bus.req !== 1'b1) begin
                fails++; $display("FAIL lock_hold[%0d]: got %h/%b/%b want 00004444/1/1", c, dn_bus.addr, dn_bus.we, dn_bus.req);
            end
            tests++; if ({m1_bus.gnt, m0_bus.gnt} !== 2'b00) begin fails++; $display("FAIL lock_nogrant[%0d]: got %b want 00", c, {m1_bus.gnt, m0_bus.gnt}); end
            step();
        end
        dn_bus.gnt = 1'b1;
        #1;
        tests++; if ({m1_bus.gnt, m0_bus.gnt} !== 2'b10 || dn_bus.wdata !== 32'hCAFE_0001) begin
            fails++; $display("FAIL lock_first: got %b/%h want 10/cafe0001", {m1_bus.gnt, m0_bus.gnt}, dn_bus.wdata);
        end
        sb.push_back('{id: 1'b1, data: 32'hE000_0001});
        last_model = 1'b1;
        step();
        m1_bus.req = 1'b0;
        #1;
        tests++; if ({m1_bus.gnt, m0_bus.gnt} !== 2'b01 || dn_bus.addr !== 32'h0000_5555) begin
            fails++; $display("FAIL lock_second: got %b/%h want 01/00005555", {m1_bus.gnt, m0_bus.gnt}, dn_bus.addr);
        end
        sb.push_back('{id: 1'b0, data: 32'hE000_0002});
        last_model = 1'b0;
        step();
        for (int r = 0; r < 2; r++) begin
            idle();
            e = sb.pop_front();
            dn_bus.rvalid = 1'b1; dn_bus.rdata = e.data;
            #1;
            tests++; if ({m1_bus.rvalid, m0_bus.rvalid} !== (e.id ? 2'b10 : 2'b01)) begin
                fails++; $display("FAIL lock_route[%0d]: got %b want %b", r, {m1_bus.rvalid, m0_bus.rvalid}, (e.id ? 2'b10 : 2'b01));
            end
            step();
        end
        idle();
    endtask

    task automatic test_full();
        idle();
        m0_bus.req = 1'b1; m0_bus.addr = 32'h0000_6000; dn_bus.gnt = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            tests++; if ({m1_bus.gnt, m0_bus.gnt} !== 2'b01) begin fails++; $display("FAIL full_fill[%0d]: got %b want 01", k, {m1_bus.gnt, m0_bus.gnt}); end
            sb.push_back('{id: 1'b0, data: 32'hF000_0000 + k});
            step();
        end
        #1;
        tests++; if (dn_bus.req !== 1'b0 || {m1_bus.gnt, m0_bus.gnt} !== 2'b00) begin
            fails++; $display("FAIL full_block: got req %b gnt %b want 0/00", dn_bus.req, {m1_bus.gnt, m0_bus.gnt});
        end
        tests++; if (dut.id_count !== 2) begin fails++; $display("FAIL full_count: got %0d want 2", dut.id_count); end
        step();
        e = sb.pop_front();
        dn_bus.rvalid = 1'b1; dn_bus.rdata = e.data;
        #1;
        tests++; if (dn_bus.req !== 1'b0) begin fails++; $display("FAIL full_nobypass: got %b want 0", dn_bus.req); end
        tests++; if (m0_bus.rvalid !== 1'b1 || m0_bus.rdata !== e.data) begin
            fails++; $display("FAIL full_rsp: got %b/%h want 1/%h", m0_bus.rvalid, m0_bus.rdata, e.data);
        end
        step();
        dn_bus.rvalid = 1'b0;
        #1;
        tests++; if (dn_bus.req !== 1'b1 || {m1_bus.gnt, m0_bus.gnt} !== 2'b01) begin
            fails++; $display("FAIL full_resume: got req %b gnt %b want 1/01", dn_bus.req, {m1_bus.gnt, m0_bus.gnt});
        end
        sb.push_back('{id: 1'b0, data: 32'hF000_0002});
        last_model = 1'b0;
        step();
        for (int r = 0; r < 2; r++) begin
            idle();
            e = sb.pop_front();
            dn_bus.rvalid = 1'b1; dn_bus.rdata = e.data;
            #1;
            tests++; if ({m1_bus.rvalid, m0_bus.rvalid} !== 2'b01 || m0_bus.rdata !== e.data) begin
                fails++; $display("FAIL full_drain[%0d]: got %b/%h want 01/%h", r, {m1_bus.rvalid, m0_bus.rvalid}, m0_bus.rdata, e.data);
            end
            step();
        end
        idle();
    endtask

    task automatic test_error();
        idle();
        dn_bus.rvalid = 1'b1; dn_bus.rdata = 32'hDEAD_BEEF;
        #1;
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_pulse: got %b want 1", err); end
        tests++; if ({m1_bus.rvalid, m0_bus.rvalid} !== 2'b00) begin fails++; $display("FAIL err_drop: got %b want 00", {m1_bus.rvalid, m0_bus.rvalid}); end
        step();
        dn_bus.rvalid = 1'b0;
        #1;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clear: got %b want 0", err); end
        step();
    endtask

    task automatic test_reset_mid();
        idle();
        m0_bus.req = 1'b1; m0_bus.addr = 32'h0000_8000; dn_bus.gnt = 1'b1;
        step();
        step();
        #1;
        tests++; if (dut.id_count !== 2) begin fails++; $display("FAIL rmid_pre: got %0d want 2", dut.id_count); end
        dn_bus.rvalid = 1'b1; m1_bus.req = 1'b1;
        rst = 1'b1;
        #1;
        tests++; if (dut.id_count !== 0) begin fails++; $display("FAIL rmid_count: got %0d want 0", dut.id_count); end
        tests++; if (dn_bus.req !== 1'b0 || {m1_bus.gnt, m0_bus.gnt} !== 2'b00 || {m1_bus.rvalid, m0_bus.rvalid} !== 2'b00 || err !== 1'b0) begin
            fails++; $display("FAIL rmid_outs: got req %b gnt %b rvalid %b err %b want all 0", dn_bus.req, {m1_bus.gnt, m0_bus.gnt}, {m1_bus.rvalid, m0_bus.rvalid}, err);
        end
        step();
        idle();
        rst = 1'b0;
        sb.delete();
        last_model = 1'b1;
        step();
        dn_bus.rvalid = 1'b1; dn_bus.rdata = 32'h0BAD_0BAD;
        #1;
        tests++; if (err !== 1'b1 || {m1_bus.rvalid, m0_bus.rvalid} !== 2'b00) begin
            fails++; $display("FAIL rmid_late: got err %b rvalid %b want 1/00", err, {m1_bus.rvalid, m0_bus.rvalid});
        end
        step();
        idle();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_push_pop();
        test_lock();
        test_full();
        test_error();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
